// File: rtl/blink_pkg.sv
// Shared types and default parameters for the blink stretcher.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int unsigned DEF_N         = 20;
  localparam int unsigned DEF_ON_TICKS  = 3;
  localparam int unsigned DEF_OFF_TICKS = 3;
  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned PHASE_W       = 4;

endpackage

// File: rtl/blink_stretcher_if.sv
// Event-in / blink-status-out signal bundle for the blink stretcher.
interface blink_stretcher_if
  import blink_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic             ev;
  logic             clr_ovf;
  logic             led;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             ovf;

  modport master (output ev, output clr_ovf,
                  input  led, input busy, input pending, input ovf);
  modport slave  (input  ev, input clr_ovf,
                  output led, output busy, output pending, output ovf);
endinterface

// File: rtl/blink_stretcher_tick_gen.sv
// Free-running 2^N prescaler; clr restarts the count so a tick lands 2^N cycles later.
module tick_gen
  import blink_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q + N'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == {N{1'b1}});

endmodule

// File: rtl/blink_stretcher.sv
// Stretches single-cycle events into visible LED blinks, queuing events that arrive mid-blink.
module blink_stretcher
  import blink_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
  parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ev,
  input  logic             clr_ovf,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             ovf
);

  localparam int unsigned PW = CNT_W + 1;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic [PW-1:0]      pend_w;
  logic               ovf_q, ovf_d;
  logic               led_q, busy_q;
  logic               tick, clr, consume_ev, dec;

  tick_gen #(.N(N)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    consume_ev = 1'b0;
    dec        = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d    = ON;
          consume_ev = 1'b1;
        end
      end
      ON: begin
        if (tick) begin
          if (phase_q == PHASE_W'(ON_TICKS - 1)) state_d = OFF;
          else                                   phase_d = phase_q + PHASE_W'(1);
        end
      end
      OFF: begin
        if (tick) begin
          if (phase_q == PHASE_W'(OFF_TICKS - 1)) begin
            // A live event is preferred over the queue so pending stays put.
            if (ev) begin
              state_d    = ON;
              consume_ev = 1'b1;
            end else if (pend_q != '0) begin
              state_d = ON;
              dec     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) phase_d = '0;
    clr = (state_d != state_q) || (state_q == IDLE);

    // Pending math one bit wide so saturation shows up as a carry.
    pend_w = {1'b0, pend_q};
    if (dec)                     pend_w = pend_w - PW'(1);
    else if (ev && !consume_ev)  pend_w = pend_w + PW'(1);

    if (pend_w[CNT_W]) begin
      pend_d = pend_q;
      ovf_d  = 1'b1;
    end else begin
      pend_d = pend_w[CNT_W-1:0];
      ovf_d  = clr_ovf ? 1'b0 : ovf_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= (state_d == ON);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_blink_stretcher.sv
// Scoreboard bench for blink_stretcher with N=2, ON_TICKS=3, OFF_TICKS=2, CNT_W=2.
module tb_blink_stretcher;

  localparam int unsigned TN   = 2;
  localparam int unsigned TON  = 3;
  localparam int unsigned TOFF = 2;
  localparam int unsigned TCW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  blink_stretcher_if #(.CNT_W(TCW)) bif ();

  blink_stretcher #(.N(TN), .ON_TICKS(TON), .OFF_TICKS(TOFF), .CNT_W(TCW)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .ev      (bif.ev),
    .clr_ovf (bif.clr_ovf),
    .led     (bif.led),
    .busy    (bif.busy),
    .pending (bif.pending),
    .ovf     (bif.ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig_val(int s);
    case (s)
      0:       return int'(bif.led);
      1:       return int'(bif.busy);
      2:       return int'(bif.pending);
      default: return int'(bif.ovf);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(int c, int s, int v, string n);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic push_range(int c0, int from, int to, int s, int v, string n);
    for (int k = from; k <= to; k++) push(c0 + k, s, v, n);
  endtask

  // Back-to-back blinks: each 12 cycles on, 8 off, idle afterwards.
  task automatic push_blinks(int c0, int nb);
    int on;
    for (int k = 1; k <= 20 * nb + 1; k++) begin
      on = 0;
      for (int b = 0; b < nb; b++)
        if (k >= 1 + 20 * b && k <= 12 + 20 * b) on = 1;
      push(c0 + k, 0, on, "led");
      push(c0 + k, 1, (k <= 20 * nb) ? 1 : 0, "busy");
    end
  endtask

  task automatic run(int len, logic [127:0] evm, logic [127:0] clm);
    for (int k = 0; k < len; k++) begin
      bif.ev      = evm[k];
      bif.clr_ovf = clm[k];
      @(negedge clk);
    end
    bif.ev      = 1'b0;
    bif.clr_ovf = 1'b0;
  endtask

  task automatic single_pulse(string tag);
    logic [127:0] m;
    int c0;
    c0 = cyc;
    m = '0; m[0] = 1'b1;
    push_blinks(c0, 1);
    push_range(c0, 1, 21, 2, 0, {tag, "_pend"});
    push_range(c0, 1, 21, 3, 0, {tag, "_ovf"});
    run(23, m, '0);
  endtask

  // Monitor: compare every scoreboard entry due this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          check($sformatf("%s@%0d_missed", sb[i].name, sb[i].cyc), -1, sb[i].val);
          sb.delete(i);
        end else if (sb[i].cyc == cyc) begin
          check($sformatf("%s@%0d", sb[i].name, sb[i].cyc), sig_val(sb[i].sig), sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] m, cm;
    int c0;
    bif.ev      = 1'b0;
    bif.clr_ovf = 1'b0;

    #1;
    check("rst_led",  int'(bif.led),     0);
    check("rst_busy", int'(bif.busy),    0);
    check("rst_pend", int'(bif.pending), 0);
    check("rst_ovf",  int'(bif.ovf),     0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    single_pulse("single");

    // Burst: three extra events while ON -> four blinks.
    c0 = cyc;
    m = '0; m[0] = 1'b1; m[2] = 1'b1; m[4] = 1'b1; m[6] = 1'b1;
    push_blinks(c0, 4);
    push_range(c0, 1, 2, 2, 0, "burst_pend");
    push_range(c0, 3, 4, 2, 1, "burst_pend");
    push_range(c0, 5, 6, 2, 2, "burst_pend");
    push_range(c0, 7, 20, 2, 3, "burst_pend");
    push_range(c0, 21, 40, 2, 2, "burst_pend");
    push_range(c0, 41, 60, 2, 1, "burst_pend");
    push_range(c0, 61, 81, 2, 0, "burst_pend");
    push_range(c0, 1, 81, 3, 0, "burst_ovf");
    run(83, m, '0);

    // Overflow, clear-vs-set priority, then ev on saturated final OFF tick.
    c0 = cyc;
    m = '0; m[0] = 1'b1; m[2] = 1'b1; m[4] = 1'b1; m[6] = 1'b1;
    m[8] = 1'b1; m[10] = 1'b1; m[20] = 1'b1;
    cm = '0; cm[10] = 1'b1; cm[14] = 1'b1;
    push_blinks(c0, 5);
    push_range(c0, 1, 2, 2, 0, "ovf_pend");
    push_range(c0, 3, 4, 2, 1, "ovf_pend");
    push_range(c0, 5, 6, 2, 2, "ovf_pend");
    push_range(c0, 7, 40, 2, 3, "ovf_pend");
    push_range(c0, 41, 60, 2, 2, "ovf_pend");
    push_range(c0, 61, 80, 2, 1, "ovf_pend");
    push_range(c0, 81, 101, 2, 0, "ovf_pend");
    push_range(c0, 1, 8, 3, 0, "ovf_flag");
    push_range(c0, 9, 14, 3, 1, "ovf_flag");
    push_range(c0, 15, 101, 3, 0, "ovf_flag");
    run(103, m, cm);

    // Event on the final OFF cycle with nothing queued: straight back to ON.
    c0 = cyc;
    m = '0; m[0] = 1'b1; m[20] = 1'b1;
    push_blinks(c0, 2);
    push_range(c0, 1, 41, 2, 0, "bound_pend");
    push_range(c0, 1, 41, 3, 0, "bound_ovf");
    run(43, m, '0);

    // Reset in the 5th ON cycle with two queued events.
    c0 = cyc;
    m = '0; m[0] = 1'b1; m[1] = 1'b1; m[3] = 1'b1;
    push_range(c0, 1, 5, 0, 1, "pre_rst_led");
    push_range(c0, 1, 5, 1, 1, "pre_rst_busy");
    push(c0 + 1, 2, 0, "pre_rst_pend");
    push_range(c0, 2, 3, 2, 1, "pre_rst_pend");
    push_range(c0, 4, 5, 2, 2, "pre_rst_pend");
    run(5, m, '0);
    #2 rst_n = 1'b0;
    #1;
    check("async_led",  int'(bif.led),     0);
    check("async_busy", int'(bif.busy),    0);
    check("async_pend", int'(bif.pending), 0);
    check("async_ovf",  int'(bif.ovf),     0);
    repeat (2) @(negedge clk);
    check("hold_led",  int'(bif.led),     0);
    check("hold_pend", int'(bif.pending), 0);
    rst_n = 1'b1;
    @(negedge clk);

    single_pulse("post_rst");

    repeat (2) @(negedge clk);
    check("sb_leftover", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_stretcher.md
BLINK_STRETCHER -- requirements
Module: blink_stretcher

Interface
REQ-001 SHALL have parameter N, default 20: prescaler width; one tick every 2^N clk cycles.
REQ-002 SHALL have parameter ON_TICKS, default 3: LED-on duration in ticks, legal range 1..15.
REQ-003 SHALL have parameter OFF_TICKS, default 3: minimum LED-off gap in ticks, legal range 1..15.
REQ-004 SHALL have parameter CNT_W, default 4: width of the pending-event counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port ev, input, 1 bit: event request; each cycle sampled high counts as one event.
REQ-008 SHALL have port clr_ovf, input, 1 bit: synchronous clear of ovf.
REQ-009 SHALL have port led, output, 1 bit: stretched, human-visible blink output.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port pending, output, CNT_W bits: number of queued, not-yet-shown events.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, set when an event is lost to saturation.

Function
REQ-013 SHALL implement FSM states IDLE, ON and OFF; led = (state==ON) (Moore, registered state only).
REQ-014 SHALL clear the prescaler and phase counter on every state entry; tick = prescaler at 2^N-1.
REQ-015 In IDLE with ev=1, SHALL enter ON next cycle; this event is consumed directly and pending is unchanged.
REQ-016 In ON, SHALL advance phase on tick; on tick with phase==ON_TICKS-1, SHALL go to OFF (led high exactly ON_TICKS*2^N cycles).
REQ-017 In OFF, SHALL go on the final tick (phase==OFF_TICKS-1) to ON if pending>0 or ev=1, else to IDLE.
REQ-018 On the OFF->ON transition, SHALL consume one event: from ev if ev=1 (pending unchanged), else pending-1.
REQ-019 ev=1 in ON or OFF, when not consumed per REQ-018, SHALL increment pending.
REQ-020 At pending = 2^CNT_W-1, an unconsumed ev SHALL leave pending unchanged and set ovf.
REQ-021 At saturation, ev plus a simultaneous consume SHALL leave pending unchanged and SHALL NOT set ovf.
REQ-022 clr_ovf=1 SHALL clear ovf next cycle; a set condition in the same cycle SHALL win (ovf stays 1).
REQ-023 ev held high for K cycles SHALL count as K events; no edge detection is done.

Reset
REQ-024 reset=0 SHALL immediately force state=IDLE, led=0, busy=0, pending=0, ovf=0, prescaler=0, phase=0, regardless of clk.
REQ-025 Reset asserted mid-ON or mid-OFF SHALL drop led to 0 at once and discard all queued events.
REQ-026 After reset deasserts, the first ev SHALL be handled exactly per REQ-015.

Structure
REQ-027 Package blink_pkg SHALL hold the state enum (IDLE, ON, OFF) and the default parameter values.
REQ-028 The prescaler SHALL be a sub-module tick_gen (params N; ports clk, reset, clr, tick).
REQ-029 Phase counter SHALL be 4 bits; pending arithmetic SHALL be done at CNT_W+1 bits and then saturated.

Verification (N=2, ON_TICKS=3, OFF_TICKS=2, CNT_W=2)
REQ-030 Single pulse: ev=1 at cycle 0 -> led=1 cycles 1-12, led=0 cycles 13-20, busy=0 from cycle 21, pending=0 throughout.
REQ-031 Burst: three single-cycle ev pulses during ON -> pending=3, then four separate blinks total, each 12 cycles high with 8-cycle gaps, then pending=0.
REQ-032 Overflow: five ev pulses during ON -> pending=3, ovf=1; clr_ovf pulse -> ovf=0 next cycle, pending still 3.
REQ-033 Boundary: ev=1 on the final OFF cycle with pending=0 -> ON next cycle, no IDLE cycle, pending stays 0.
REQ-034 Reset mid-blink: reset=0 asserted at cycle 5 of ON with pending=2 -> led=0, pending=0, busy=0 without waiting for a clk edge.
